// File: rtl/ibex_rf_wipe_pkg.sv
// Shared types and constants for the register-file wipe sequencer.
//   rf_wipe_state_e : sequencer state (IDLE / WIPE / DONE)
//   LFSR_TAPS       : Galois feedback mask for the optional wipe-data LFSR
//   RF_ADDR_W       : width of the register-file write address bus
//   num_words()     : architectural register count for RV32I / RV32E
//   lfsr_step()     : one right-shifting Galois LFSR step
package ibex_rf_wipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WIPE = 2'b01,
    DONE = 2'b10
  } rf_wipe_state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int unsigned RF_ADDR_W = 5;

  function automatic int unsigned num_words(input bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/ibex_rf_wipe_if.sv
// Write-port bundle between the core writeback stage, the wipe sequencer
// and the register file.
//   core_waddr/core_wdata/core_we : core writeback request
//   core_wr_stall                 : request not accepted this cycle, hold it
//   rf_waddr/rf_wdata/rf_we       : register-file write port
// master : core / environment side, slave : wipe sequencer side.
interface ibex_rf_wipe_if #(
  parameter int unsigned DataWidth = 32
);
  logic [4:0]           core_waddr;
  logic [DataWidth-1:0] core_wdata;
  logic                 core_we;
  logic                 core_wr_stall;
  logic [4:0]           rf_waddr;
  logic [DataWidth-1:0] rf_wdata;
  logic                 rf_we;

  modport master (
    output core_waddr, core_wdata, core_we,
    input  core_wr_stall, rf_waddr, rf_wdata, rf_we
  );

  modport slave (
    input  core_waddr, core_wdata, core_we,
    output core_wr_stall, rf_waddr, rf_wdata, rf_we
  );
endinterface

// File: rtl/ibex_rf_wipe_lfsr.sv
// 32-bit Galois LFSR producing pseudo-random wipe data.
//   clk_i, rst_ni : clock, asynchronous active-low reset (state -> Seed)
//   en_i          : advance one step this cycle
//   state_o       : current LFSR state
module ibex_rf_wipe_lfsr
  import ibex_rf_wipe_pkg::*;
#(
  parameter logic [31:0] Seed = 32'h8BAD_F00D
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] state_o
);

  logic [31:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   lfsr_q <= Seed;
    else if (en_i) lfsr_q <= lfsr_step(lfsr_q);
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/ibex_rf_wipe_ctrl.sv
// Write-port sequencer in front of the flip-flop register file. Passes core
// writeback through, and on request (or after reset) overwrites x1..xN-1
// with wipe data while stalling core writes.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wipe_req_i    : start a wipe when sampled high in IDLE or DONE
//   wipe_busy_o   : high while wiping
//   wipe_done_o   : one-cycle pulse after the last wipe write
//   bus (slave)   : core writeback in, stall out, register-file write out
// Build option: define IBEX_RF_WIPE_LFSR_EN to source wipe data from an LFSR
// seeded with LfsrSeed; otherwise every wipe write uses WipeVal.
module ibex_rf_wipe_ctrl
  import ibex_rf_wipe_pkg::*;
#(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter bit                   WipeOnReset = 1'b1,
  parameter logic [DataWidth-1:0] WipeVal     = '0,
  parameter logic [31:0]          LfsrSeed    = 32'h8BAD_F00D
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wipe_req_i,
  output logic wipe_busy_o,
  output logic wipe_done_o,
  ibex_rf_wipe_if.slave bus
);

  localparam int unsigned    NumWords   = num_words(RV32E);
  localparam int unsigned    AddrWidth  = RV32E ? 4 : 5;
  localparam rf_wipe_state_e ResetState = WipeOnReset ? WIPE : IDLE;
  localparam logic [AddrWidth-1:0] FirstAddr = AddrWidth'(1);
  localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(NumWords - 1);

  rf_wipe_state_e       state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [DataWidth-1:0] wipe_data;

`ifdef IBEX_RF_WIPE_LFSR_EN
  logic [31:0] lfsr_state;

  // Advances only while wiping so each register gets the next value and
  // consecutive wipes continue the sequence.
  ibex_rf_wipe_lfsr #(
    .Seed(LfsrSeed)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_q == WIPE),
    .state_o(lfsr_state)
  );

  assign wipe_data = DataWidth'(lfsr_state);

  logic unused_wipe_val;
  assign unused_wipe_val = ^WipeVal;
`else
  assign wipe_data = WipeVal;

  logic unused_lfsr_seed;
  assign unused_lfsr_seed = ^LfsrSeed;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ResetState;
      cnt_q   <= FirstAddr;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    bus.rf_we         = bus.core_we;
    bus.rf_waddr      = bus.core_waddr;
    bus.rf_wdata      = bus.core_wdata;
    bus.core_wr_stall = 1'b0;
    wipe_busy_o       = 1'b0;
    wipe_done_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Core write in the request cycle still goes through.
        if (wipe_req_i) state_d = WIPE;
      end
      WIPE: begin
        bus.rf_we         = 1'b1;
        bus.rf_waddr      = RF_ADDR_W'(cnt_q);
        bus.rf_wdata      = wipe_data;
        bus.core_wr_stall = bus.core_we;
        wipe_busy_o       = 1'b1;
        // Requests during a wipe are dropped, not queued.
        if (cnt_q == LastAddr) begin
          cnt_d   = FirstAddr;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + AddrWidth'(1);
        end
      end
      DONE: begin
        wipe_done_o = 1'b1;
        state_d     = wipe_req_i ? WIPE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
